// File: rtl/gpio_pkg.sv
// Shared sizing, types and select-validity helper for the four-port GPIO block.
package gpio_pkg;

    localparam int GPIO_WIDTH     = 16;
    localparam int GPIO_NUM_PORTS = 4;

    typedef logic [GPIO_WIDTH-1:0]     port_word;
    typedef logic [GPIO_NUM_PORTS-1:0] port_sel;

    // Exactly one bit set; an all-zero or multi-bit select is treated as "no port".
    function automatic logic is_one_hot(input port_sel sel);
        return (sel != '0) && ((sel & (sel - port_sel'(1))) == '0);
    endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: direction and output latch, with gated tri-state enable and drive value.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] dir_in,
    input  logic [WIDTH-1:0] out_in,
    output logic [WIDTH-1:0] drive_en,
    output logic [WIDTH-1:0] drive_val
);

    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] out_reg;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            dir_reg <= '0;
            out_reg <= '0;
        end else if (sel) begin
            dir_reg <= dir_in;
            out_reg <= out_in;
        end
    end

    // Outputs are zero when unselected so the top can OR all ports together.
    assign drive_en  = sel ? dir_reg : '0;
    assign drive_val = sel ? (dir_reg & out_reg) : '0;

endmodule

// File: rtl/gpio_module.sv
// Four-port bidirectional GPIO: one-hot port select, shared pin bus, registered readback.
module gpio_module
    import gpio_pkg::*;
#(
    parameter int N                       = GPIO_WIDTH - 1,
    parameter int NUM_BITS_IN_PORT_SELECT = GPIO_NUM_PORTS - 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_BITS_IN_PORT_SELECT:0] i_port_select,
    input  logic [N:0]                       i_data_dir,
    input  logic [N:0]                       i_data_transmit,
    output logic [N:0]                       o_data_received,
    inout  wire  [N:0]                       io_pin_states
);

    localparam int NUM_PORTS = NUM_BITS_IN_PORT_SELECT + 1;

    logic           sel_valid;
    logic [N:0]     port_en  [NUM_PORTS];
    logic [N:0]     port_val [NUM_PORTS];
    logic [N:0]     pin_en;
    logic [N:0]     pin_val;

    assign sel_valid = is_one_hot(i_port_select);

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        gpio_port #(
            .WIDTH (N + 1)
        ) u_port (
            .clk_sys   (i_clk),
            .rst       (i_rst),
            .sel       (sel_valid && i_port_select[k]),
            .dir_in    (i_data_dir),
            .out_in    (i_data_transmit),
            .drive_en  (port_en[k]),
            .drive_val (port_val[k])
        );
    end

    // At most one port contributes non-zero terms, so OR acts as the select mux.
    always_comb begin
        pin_en  = '0;
        pin_val = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pin_en  = pin_en  | port_en[k];
            pin_val = pin_val | port_val[k];
        end
    end

    for (genvar b = 0; b <= N; b++) begin : g_pin
        assign io_pin_states[b] = pin_en[b] ? pin_val[b] : 1'bz;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_received <= '0;
        end else if (sel_valid) begin
            o_data_received <= (pin_en & pin_val) | (~pin_en & io_pin_states);
        end
    end

endmodule

// File: tb/tb_gpio_module.sv
// Self-checking bench for gpio_module: vector table plus readback scoreboard queue.
module tb_gpio_module;

    typedef struct {
        string       name;
        logic [3:0]  sel;
        logic [15:0] dir;
        logic [15:0] tx;
        logic [15:0] ext_en;
        logic [15:0] ext_val;
        logic [15:0] exp_pins;
        logic        chk_rx;
        logic [15:0] exp_rx;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk;
        logic [15:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [15:0] dir;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [15:0] ext_en;
    logic [15:0] ext_val;
    wire  [15:0] pins;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar b = 0; b < 16; b++) begin : g_ext
        assign pins[b] = ext_en[b] ? ext_val[b] : 1'bz;
    end

    gpio_module dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_port_select   (sel),
        .i_data_dir      (dir),
        .i_data_transmit (tx),
        .o_data_received (rx),
        .io_pin_states   (pins)
    );

    function automatic vec_t mk(input string name, input logic [3:0] s, input logic [15:0] d,
                                input logic [15:0] t, input logic [15:0] een, input logic [15:0] eval,
                                input logic [15:0] epins, input logic crx, input logic [15:0] erx);
        vec_t v;
        v.name = name; v.sel = s; v.dir = d; v.tx = t; v.ext_en = een; v.ext_val = eval;
        v.exp_pins = epins; v.chk_rx = crx; v.exp_rx = erx;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_rx();
        sb_t e;
        e = sb.pop_front();
        if (e.chk) check({e.name, "_rx"}, rx, e.val);
    endtask

    task automatic drive(input vec_t v);
        sel = v.sel; dir = v.dir; tx = v.tx; ext_en = v.ext_en; ext_val = v.ext_val;
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clk);
        drive(v);
        e.name = v.name; e.chk = v.chk_rx; e.val = v.exp_rx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_rx();
        check({v.name, "_pins"}, pins, v.exp_pins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        logic [3:0] s;

        // External levels seen through each port after reset (all bits inputs).
        vecs.push_back(mk("rd_p0", 4'b0001, 16'h0000, 16'h0000, 16'hFFFF, 16'hC3A5, 16'hC3A5, 1'b1, 16'hC3A5));
        vecs.push_back(mk("rd_p1", 4'b0010, 16'h0000, 16'h0000, 16'hFFFF, 16'h5A3C, 16'h5A3C, 1'b1, 16'h5A3C));
        vecs.push_back(mk("rd_p2", 4'b0100, 16'h0000, 16'h0000, 16'hFFFF, 16'h0FF0, 16'h0FF0, 1'b1, 16'h0FF0));
        vecs.push_back(mk("rd_p3", 4'b1000, 16'h0000, 16'h0000, 16'hFFFF, 16'hF00F, 16'hF00F, 1'b1, 16'hF00F));
        for (int k = 0; k < 4; k++) begin
            s = 4'b0001 << k;
            vecs.push_back(mk($sformatf("p%0d_outA", k), s, 16'hFFFF, 16'hAAAA, 16'h0000, 16'h0000, 16'hAAAA, 1'b0, 16'h0000));
            vecs.push_back(mk($sformatf("p%0d_outB", k), s, 16'hFFFF, 16'hAAAA, 16'h0000, 16'h0000, 16'hAAAA, 1'b1, 16'hAAAA));
            vecs.push_back(mk($sformatf("p%0d_mixA", k), s, 16'h00FF, 16'hAAAA, 16'hFF00, 16'h7500, 16'h75AA, 1'b1, 16'hAAAA));
            vecs.push_back(mk($sformatf("p%0d_mixB", k), s, 16'h00FF, 16'hAAAA, 16'hFF00, 16'h7500, 16'h75AA, 1'b1, 16'h75AA));
            vecs.push_back(mk($sformatf("p%0d_zeroA", k), s, 16'h00FF, 16'h0000, 16'hFF00, 16'hFF00, 16'hFF00, 1'b1, 16'hFFAA));
            vecs.push_back(mk($sformatf("p%0d_zeroB", k), s, 16'h00FF, 16'h0000, 16'hFF00, 16'hFF00, 16'hFF00, 1'b1, 16'hFF00));
        end
        vecs.push_back(mk("resel_p0", 4'b0001, 16'h00FF, 16'h0000, 16'hFF00, 16'h3C00, 16'h3C00, 1'b1, 16'h3C00));
        vecs.push_back(mk("inv_none", 4'b0000, 16'hFFFF, 16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h3C00));
        vecs.push_back(mk("inv_multi", 4'b0011, 16'hFFFF, 16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h3C00));
        vecs.push_back(mk("post_p0", 4'b0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0F0F, 16'h0F0F, 1'b1, 16'h0F00));
        vecs.push_back(mk("post_p1", 4'b0010, 16'h0000, 16'h0000, 16'hFFFF, 16'hF0F0, 16'hF0F0, 1'b1, 16'hF000));

        // Reset for two edges with the bus held externally.
        rst = 1'b1; sel = 4'b0001; dir = 16'hFFFF; tx = 16'hFFFF;
        ext_en = 16'hFFFF; ext_val = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx", rx, 16'h0000);
        check("reset_pins", pins, 16'h1234);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset wins over a simultaneous write to port 2.
        @(negedge clk);
        rst = 1'b1;
        drive(mk("rst_wr", 4'b0100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000));
        e.name = "rst_prio"; e.chk = 1'b1; e.val = 16'h0000;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_rx();
        check("rst_prio_pins", pins, 16'h0000);
        rst = 1'b0;
        apply(mk("rst_p2_in", 4'b0100, 16'h0000, 16'h0000, 16'hFFFF, 16'h8421, 16'h8421, 1'b1, 16'h8421));

        // Select change releases and restores drive without a clock edge.
        apply(mk("sw_wr", 4'b0100, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h0000));
        @(negedge clk);
        sel = 4'b0001; ext_en = 16'hFFFF; ext_val = 16'h0000;
        #1;
        check("sw_release_pins", pins, 16'h0000);
        sel = 4'b0100; ext_en = 16'h0000;
        #1;
        check("sw_restore_pins", pins, 16'h1234);
        apply(mk("sw_hold", 4'b0100, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b1, 16'h1234));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
